branch_resolve_unit: RTL and testbench

Branch resolution and misprediction-recovery block feeding the direction predictor's update port. Tracks every fetched instruction's PC and predicted direction through ID and EX, emits the speculative history update at fetch, and on an EX-stage mismatch emits the rollback pulses, pipeline flush and corrected fetch PC. It produces `corrected_en/corrected_result`, `rollback_en_id/rollback_en_ex` and `pc_id/pc_ex`, which the history predictor consumes.

---
 rtl/bru_pkg.sv | 22 ++
 rtl/bru_track_stage.sv | 26 ++
 rtl/branch_resolve_unit.sv | 114 +++++++++++
 tb/tb_branch_resolve_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// Shared types for the branch resolve unit: per-stage tracking entry,
// the bubble value and the sequential fetch step.
package bru_pkg;

  localparam int BRU_PC_W = 32;
  localparam int PC_STEP  = 4;

  typedef struct packed {
    logic                valid;
    logic                is_br;
    logic                pred;
    logic [BRU_PC_W-1:0] pc;
  } bru_entry_t;

  localparam bru_entry_t BRU_BUBBLE = '{
    valid: 1'b0,
    is_br: 1'b0,
    pred:  1'b0,
    pc:    '0
  };

endpackage

// File: rtl/bru_track_stage.sv
// One tracking entry register: hold on stall, bubble on flush, else load.
// Ports: clk, rst_n (sync, active-low), hold, bubble, d (next entry), q.
module bru_track_stage
  import bru_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hold,
  input  logic       bubble,
  input  bru_entry_t d,
  output bru_entry_t q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= BRU_BUBBLE;
    end else if (hold) begin
      q <= q;
    end else if (bubble) begin
      q <= BRU_BUBBLE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution / misprediction recovery. Tracks IF->ID->EX entries,
// emits speculative history shifts, rollbacks, flush and redirect PC.
// Ports: clk, rst_n, PL_stall, br_if, pred_taken_if, pc_if, br_taken_ex,
// br_target_ex in; corrected_*, rollback_en_*, pc_id/pc_ex, flush,
// redirect_en/redirect_pc, stat_* out. PC_WIDTH must not exceed 32.
// Optional macro BRU_STATS_EN builds saturating branch/mispredict counters.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int STAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  PL_stall,
  input  logic                  br_if,
  input  logic                  pred_taken_if,
  input  logic [PC_WIDTH-1:0]   pc_if,
  input  logic                  br_taken_ex,
  input  logic [PC_WIDTH-1:0]   br_target_ex,
  output logic                  corrected_en,
  output logic                  corrected_result,
  output logic                  rollback_en_id,
  output logic                  rollback_en_ex,
  output logic [PC_WIDTH-1:0]   pc_id,
  output logic [PC_WIDTH-1:0]   pc_ex,
  output logic                  flush,
  output logic                  redirect_en,
  output logic [PC_WIDTH-1:0]   redirect_pc,
  output logic [STAT_WIDTH-1:0] stat_branches,
  output logic [STAT_WIDTH-1:0] stat_mispredicts
);

  bru_entry_t if_e;
  bru_entry_t id_q;
  bru_entry_t ex_q;
  logic       live;
  logic       mispredict;
  logic [PC_WIDTH-1:0] ex_pc;

  // Pulses are masked during reset so nothing leaks to the predictor.
  assign live = rst_n & ~PL_stall;

  assign mispredict = live & ex_q.valid & ex_q.is_br
                    & (br_taken_ex != ex_q.pred);

  always_comb begin
    if_e       = BRU_BUBBLE;
    if_e.valid = 1'b1;
    if_e.is_br = br_if;
    if_e.pred  = pred_taken_if;
    if_e.pc    = BRU_PC_W'(pc_if);
  end

  bru_track_stage u_id (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (PL_stall),
    .bubble (mispredict),
    .d      (if_e),
    .q      (id_q)
  );

  bru_track_stage u_ex (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (PL_stall),
    .bubble (mispredict),
    .d      (id_q),
    .q      (ex_q)
  );

  assign ex_pc = PC_WIDTH'(ex_q.pc);

  assign corrected_en     = br_if & live & ~mispredict;
  assign corrected_result = pred_taken_if;
  assign rollback_en_ex   = mispredict;
  assign rollback_en_id   = mispredict & id_q.valid & id_q.is_br;
  assign flush            = mispredict;
  assign redirect_en      = mispredict;
  assign redirect_pc      = br_taken_ex ? br_target_ex
                          : ex_pc + PC_WIDTH'(PC_STEP);
  assign pc_id            = PC_WIDTH'(id_q.pc);
  assign pc_ex            = ex_pc;

`ifdef BRU_STATS_EN
  logic                  resolved;
  logic [STAT_WIDTH-1:0] n_br;
  logic [STAT_WIDTH-1:0] n_mp;

  assign resolved = live & ex_q.valid & ex_q.is_br;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_br <= '0;
      n_mp <= '0;
    end else begin
      if (resolved && n_br != '1) begin
        n_br <= n_br + STAT_WIDTH'(1);
      end
      if (mispredict && n_mp != '1) begin
        n_mp <= n_mp + STAT_WIDTH'(1);
      end
    end
  end

  assign stat_branches    = n_br;
  assign stat_mispredicts = n_mp;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed vector table
// plus hand-written stall, reset-recovery and statistics sequences.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PL_stall;
  logic        br_if;
  logic        pred_taken_if;
  logic [31:0] pc_if;
  logic        br_taken_ex;
  logic [31:0] br_target_ex;
  logic        corrected_en;
  logic        corrected_result;
  logic        rollback_en_id;
  logic        rollback_en_ex;
  logic [31:0] pc_id;
  logic [31:0] pc_ex;
  logic        flush;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [1:0]  stat_branches;
  logic [1:0]  stat_mispredicts;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .PC_WIDTH   (32),
    .STAT_WIDTH (2)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .PL_stall         (PL_stall),
    .br_if            (br_if),
    .pred_taken_if    (pred_taken_if),
    .pc_if            (pc_if),
    .br_taken_ex      (br_taken_ex),
    .br_target_ex     (br_target_ex),
    .corrected_en     (corrected_en),
    .corrected_result (corrected_result),
    .rollback_en_id   (rollback_en_id),
    .rollback_en_ex   (rollback_en_ex),
    .pc_id            (pc_id),
    .pc_ex            (pc_ex),
    .flush            (flush),
    .redirect_en      (redirect_en),
    .redirect_pc      (redirect_pc),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  typedef struct {
    logic        stall;
    logic        br;
    logic        pred;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
    logic        ce;
    logic        rbid;
    logic        rbex;
    logic        fl;
    logic [31:0] rpc;
    logic [31:0] pid;
    logic [31:0] pex;
    logic        chk_pc;
  } vec_t;

  vec_t vt [20];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic b, input logic p,
                       input logic [31:0] pc, input logic t,
                       input logic [31:0] tg);
    PL_stall      = s;
    br_if         = b;
    pred_taken_if = p;
    pc_if         = pc;
    br_taken_ex   = t;
    br_target_ex  = tg;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string name);
    chk({name, ".ce"}, 32'(corrected_en), 0);
    chk({name, ".rb_ex"}, 32'(rollback_en_ex), 0);
    chk({name, ".rb_id"}, 32'(rollback_en_id), 0);
    chk({name, ".flush"}, 32'(flush), 0);
  endtask

  initial begin
    int rb_count;
    int exp_st;

    vt[0]  = '{0,0,0,32'h10,0,32'h0,   0,0,0,0,32'h0,  32'h0,  32'h0,  1};
    vt[1]  = '{0,0,0,32'h14,0,32'h0,   0,0,0,0,32'h0,  32'h10, 32'h0,  1};
    vt[2]  = '{0,0,0,32'h18,1,32'h998, 0,0,0,0,32'h0,  32'h14, 32'h10, 1};
    vt[3]  = '{0,1,1,32'h100,0,32'h0,  1,0,0,0,32'h0,  32'h18, 32'h14, 1};
    vt[4]  = '{0,0,0,32'h104,0,32'h0,  0,0,0,0,32'h0,  32'h100,32'h18, 1};
    vt[5]  = '{0,0,0,32'h108,1,32'h500,0,0,0,0,32'h0,  32'h104,32'h100,1};
    vt[6]  = '{0,1,1,32'h100,0,32'h0,  1,0,0,0,32'h0,  32'h108,32'h104,1};
    vt[7]  = '{0,0,0,32'h104,0,32'h0,  0,0,0,0,32'h0,  32'h100,32'h108,1};
    vt[8]  = '{0,0,0,32'h108,0,32'h0,  0,0,1,1,32'h104,32'h104,32'h100,1};
    vt[9]  = '{0,0,0,32'h104,0,32'h0,  0,0,0,0,32'h0,  32'h0,  32'h0,  0};
    vt[10] = '{0,0,0,32'h108,0,32'h0,  0,0,0,0,32'h0,  32'h0,  32'h0,  0};
    vt[11] = '{0,1,0,32'h200,0,32'h0,  1,0,0,0,32'h0,  32'h108,32'h104,1};
    vt[12] = '{0,1,1,32'h204,0,32'h0,  1,0,0,0,32'h0,  32'h200,32'h108,1};
    vt[13] = '{0,1,1,32'h208,1,32'h300,0,1,1,1,32'h300,32'h204,32'h200,1};
    vt[14] = '{0,0,0,32'h300,1,32'h0,  0,0,0,0,32'h0,  32'h0,  32'h0,  0};
    vt[15] = '{0,0,0,32'h304,0,32'h0,  0,0,0,0,32'h0,  32'h0,  32'h0,  0};
    vt[16] = '{0,1,1,32'hFFFFFFFC,0,32'h0,
               1,0,0,0,32'h0,  32'h304,32'h300,1};
    vt[17] = '{0,0,0,32'h0,0,32'h0,
               0,0,0,0,32'h0,  32'hFFFFFFFC,32'h304,1};
    vt[18] = '{0,0,0,32'h4,0,32'h0,
               0,0,1,1,32'h0,  32'h0,32'hFFFFFFFC,1};
    vt[19] = '{0,0,0,32'h0,0,32'h0,    0,0,0,0,32'h0,  32'h0,  32'h0,  0};

    // reset, with a branch in IF to show pulses stay masked
    rst_n = 1'b0;
    drive(0, 1, 1, 32'h40, 1, 32'h80);
    tick();
    tick();
    chk("rst.ce", 32'(corrected_en), 0);
    chk("rst.rb_ex", 32'(rollback_en_ex), 0);
    chk("rst.pc_id", pc_id, 0);
    chk("rst.pc_ex", pc_ex, 0);
    chk("rst.stat_br", 32'(stat_branches), 0);
    chk("rst.stat_mp", 32'(stat_mispredicts), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(vt[i].stall, vt[i].br, vt[i].pred, vt[i].pc,
            vt[i].taken, vt[i].tgt);
      chk($sformatf("v%0d.ce", i), 32'(corrected_en), 32'(vt[i].ce));
      chk($sformatf("v%0d.cr", i), 32'(corrected_result),
          32'(vt[i].pred));
      chk($sformatf("v%0d.rb_id", i), 32'(rollback_en_id),
          32'(vt[i].rbid));
      chk($sformatf("v%0d.rb_ex", i), 32'(rollback_en_ex),
          32'(vt[i].rbex));
      chk($sformatf("v%0d.flush", i), 32'(flush), 32'(vt[i].fl));
      chk($sformatf("v%0d.redir_en", i), 32'(redirect_en),
          32'(vt[i].fl));
      if (vt[i].fl)
        chk($sformatf("v%0d.redir_pc", i), redirect_pc, vt[i].rpc);
      if (vt[i].chk_pc) begin
        chk($sformatf("v%0d.pc_id", i), pc_id, vt[i].pid);
        chk($sformatf("v%0d.pc_ex", i), pc_ex, vt[i].pex);
      end
      tick();
    end

    // EX mismatch held under stall for 3 cycles
    drive(0, 1, 1, 32'h400, 0, 32'h0);
    chk("stl.setup_ce", 32'(corrected_en), 1);
    tick();
    drive(0, 0, 0, 32'h404, 0, 32'h0);
    tick();
    rb_count = 0;
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 1, 32'h408, 0, 32'h0);
      chk_quiet($sformatf("stl%0d", k));
      chk($sformatf("stl%0d.pc_ex", k), pc_ex, 32'h400);
      rb_count += int'(rollback_en_ex);
      tick();
    end
    drive(0, 0, 0, 32'h408, 0, 32'h0);
    chk("stl.release_redir", redirect_pc, 32'h404);
    rb_count += int'(rollback_en_ex);
    tick();
    drive(0, 0, 0, 32'h404, 0, 32'h0);
    rb_count += int'(rollback_en_ex);
    tick();
    chk("stl.rb_once", 32'(rb_count), 1);

    // reset arriving while a mismatch waits under stall
    drive(0, 1, 0, 32'h500, 0, 32'h0);
    tick();
    drive(0, 0, 0, 32'h504, 0, 32'h0);
    tick();
    drive(1, 0, 0, 32'h508, 1, 32'h600);
    chk("rr.stalled_rb", 32'(rollback_en_ex), 0);
    tick();
    rst_n = 1'b0;
    drive(1, 0, 0, 32'h508, 1, 32'h600);
    chk("rr.in_rst_rb", 32'(rollback_en_ex), 0);
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 32'h600, 1, 32'h600);
    chk_quiet("rr.after");
    chk("rr.pc_ex", pc_ex, 0);
    chk("rr.pc_id", pc_id, 0);
    chk("rr.stat_mp", 32'(stat_mispredicts), 0);
    tick();

    // five mispredicts against a 2-bit counter
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 1, 32'h700 + 32'(16 * k), 0, 32'h0);
      tick();
      drive(0, 0, 0, 32'h704 + 32'(16 * k), 0, 32'h0);
      tick();
      drive(0, 0, 0, 32'h708 + 32'(16 * k), 0, 32'h0);
      chk($sformatf("st%0d.rb_ex", k), 32'(rollback_en_ex), 1);
      tick();
`ifdef BRU_STATS_EN
      exp_st = (k + 1 > 3) ? 3 : k + 1;
`else
      exp_st = 0;
`endif
      chk($sformatf("st%0d.mp", k), 32'(stat_mispredicts), 32'(exp_st));
      chk($sformatf("st%0d.br", k), 32'(stat_branches), 32'(exp_st));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
